// File: rtl/sysbus_arbiter.sv
// Two-port round-robin arbiter that issues one Sysbus line read at a time.
// Response beats go back to the port that won the arbitration.
module sysbus_arbiter #(
  parameter int BUS_DATA_WIDTH = 64,
  parameter int BUS_TAG_WIDTH  = 13,
  parameter int BEATS          = 8
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      p0_req,
  input  logic                      p1_req,
  input  logic [63:0]               p0_addr,
  input  logic [63:0]               p1_addr,
  output logic                      p0_gnt,
  output logic                      p1_gnt,
  output logic                      p0_rvalid,
  output logic                      p1_rvalid,
  output logic [BUS_DATA_WIDTH-1:0] p0_rdata,
  output logic [BUS_DATA_WIDTH-1:0] p1_rdata,
  output logic                      p0_rlast,
  output logic                      p1_rlast,
  output logic                      bus_reqcyc,
  input  logic                      bus_reqack,
  output logic [BUS_DATA_WIDTH-1:0] bus_req,
  output logic [BUS_TAG_WIDTH-1:0]  bus_reqtag,
  input  logic                      bus_respcyc,
  output logic                      bus_respack,
  input  logic [BUS_DATA_WIDTH-1:0] bus_resp,
  input  logic [BUS_TAG_WIDTH-1:0]  bus_resptag
);

  localparam logic       SYSBUS_READ   = 1'b1;
  localparam logic [3:0] SYSBUS_MEMORY = 4'b0001;
  localparam int         CNT_W         = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BEATS - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    RESP = 2'd2
  } state_t;

  function automatic logic [BUS_TAG_WIDTH-1:0] read_tag(input logic id);
    logic [31:0] tag;
    tag       = 32'd0;
    tag[12]   = SYSBUS_READ;
    tag[11:8] = SYSBUS_MEMORY;
    tag[0]    = id;
    return tag[BUS_TAG_WIDTH-1:0];
  endfunction

  // Requests are always whole 64-byte lines.
  function automatic logic [BUS_DATA_WIDTH-1:0] line_addr(input logic [63:0] addr);
    logic [63:0] line;
    line = {addr[63:6], 6'b000000};
    return BUS_DATA_WIDTH'(line);
  endfunction

  state_t                    state_r, state_s;
  logic                      owner_r, owner_s;
  logic                      prio_r, prio_s;
  logic [CNT_W-1:0]          cnt_r, cnt_s;
  logic                      p0_gnt_r, p0_gnt_s, p1_gnt_r, p1_gnt_s;
  logic                      p0_rvalid_r, p0_rvalid_s, p1_rvalid_r, p1_rvalid_s;
  logic                      p0_rlast_r, p0_rlast_s, p1_rlast_r, p1_rlast_s;
  logic [BUS_DATA_WIDTH-1:0] p0_rdata_r, p0_rdata_s, p1_rdata_r, p1_rdata_s;
  logic                      bus_reqcyc_r, bus_reqcyc_s;
  logic [BUS_DATA_WIDTH-1:0] bus_req_r, bus_req_s;
  logic [BUS_TAG_WIDTH-1:0]  bus_reqtag_r, bus_reqtag_s;
  logic                      win_s;
  logic                      unused_s;

  assign unused_s = ^bus_resptag;

  // Next-state and next-output logic for the arbitration / transfer FSM.
  always_comb begin
    state_s      = state_r;
    owner_s      = owner_r;
    prio_s       = prio_r;
    cnt_s        = cnt_r;
    p0_gnt_s     = 1'b0;
    p1_gnt_s     = 1'b0;
    p0_rvalid_s  = 1'b0;
    p1_rvalid_s  = 1'b0;
    p0_rlast_s   = 1'b0;
    p1_rlast_s   = 1'b0;
    p0_rdata_s   = p0_rdata_r;
    p1_rdata_s   = p1_rdata_r;
    bus_reqcyc_s = bus_reqcyc_r;
    bus_req_s    = bus_req_r;
    bus_reqtag_s = bus_reqtag_r;
    // prio_r names the port that wins a tie.
    win_s        = (p0_req && p1_req) ? prio_r : p1_req;
    case (state_r)
      IDLE: begin
        if (p0_req || p1_req) begin
          owner_s      = win_s;
          p0_gnt_s     = ~win_s;
          p1_gnt_s     = win_s;
          bus_reqcyc_s = 1'b1;
          bus_req_s    = line_addr(win_s ? p1_addr : p0_addr);
          bus_reqtag_s = read_tag(win_s);
          state_s      = REQ;
        end else begin
          state_s = IDLE;
        end
      end
      REQ: begin
        if (bus_reqack) begin
          bus_reqcyc_s = 1'b0;
          bus_req_s    = {BUS_DATA_WIDTH{1'b0}};
          bus_reqtag_s = {BUS_TAG_WIDTH{1'b0}};
          cnt_s        = {CNT_W{1'b0}};
          state_s      = RESP;
        end else begin
          state_s = REQ;
        end
      end
      RESP: begin
        if (bus_respcyc) begin
          if (owner_r) begin
            p1_rdata_s  = bus_resp;
            p1_rvalid_s = 1'b1;
            p1_rlast_s  = (cnt_r == LAST_BEAT);
          end else begin
            p0_rdata_s  = bus_resp;
            p0_rvalid_s = 1'b1;
            p0_rlast_s  = (cnt_r == LAST_BEAT);
          end
          if (cnt_r == LAST_BEAT) begin
            cnt_s   = {CNT_W{1'b0}};
            prio_s  = ~owner_r;
            state_s = IDLE;
          end else begin
            cnt_s = cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
          end
        end else begin
          state_s = RESP;
        end
      end
      default: begin
        state_s = IDLE;
      end
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r      <= IDLE;
      owner_r      <= 1'b0;
      prio_r       <= 1'b0;
      cnt_r        <= {CNT_W{1'b0}};
      p0_gnt_r     <= 1'b0;
      p1_gnt_r     <= 1'b0;
      p0_rvalid_r  <= 1'b0;
      p1_rvalid_r  <= 1'b0;
      p0_rlast_r   <= 1'b0;
      p1_rlast_r   <= 1'b0;
      p0_rdata_r   <= {BUS_DATA_WIDTH{1'b0}};
      p1_rdata_r   <= {BUS_DATA_WIDTH{1'b0}};
      bus_reqcyc_r <= 1'b0;
      bus_req_r    <= {BUS_DATA_WIDTH{1'b0}};
      bus_reqtag_r <= {BUS_TAG_WIDTH{1'b0}};
    end else begin
      state_r      <= state_s;
      owner_r      <= owner_s;
      prio_r       <= prio_s;
      cnt_r        <= cnt_s;
      p0_gnt_r     <= p0_gnt_s;
      p1_gnt_r     <= p1_gnt_s;
      p0_rvalid_r  <= p0_rvalid_s;
      p1_rvalid_r  <= p1_rvalid_s;
      p0_rlast_r   <= p0_rlast_s;
      p1_rlast_r   <= p1_rlast_s;
      p0_rdata_r   <= p0_rdata_s;
      p1_rdata_r   <= p1_rdata_s;
      bus_reqcyc_r <= bus_reqcyc_s;
      bus_req_r    <= bus_req_s;
      bus_reqtag_r <= bus_reqtag_s;
    end
  end

  // The bus expects the acknowledge in the same cycle as the beat.
  assign bus_respack = ~reset && (state_r == RESP) && bus_respcyc;

  assign p0_gnt     = p0_gnt_r;
  assign p1_gnt     = p1_gnt_r;
  assign p0_rvalid  = p0_rvalid_r;
  assign p1_rvalid  = p1_rvalid_r;
  assign p0_rlast   = p0_rlast_r;
  assign p1_rlast   = p1_rlast_r;
  assign p0_rdata   = p0_rdata_r;
  assign p1_rdata   = p1_rdata_r;
  assign bus_reqcyc = bus_reqcyc_r;
  assign bus_req    = bus_req_r;
  assign bus_reqtag = bus_reqtag_r;

endmodule
